// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, the decode op
// encoding {op_div, op_signed}, and default operand width.
package mdu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } mdu_op_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input mdu_op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Combinational datapath: operand magnitudes, one shift-add / restoring
// shift-subtract step, and the sign-corrected result of a finished step.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  sign_mode_i,
   input  logic [DATA_W-1:0]     src_a_i,
   input  logic [DATA_W-1:0]     src_b_i,
   output logic [DATA_W-1:0]     mag_a_o,
   output logic [DATA_W-1:0]     mag_b_o,
   input  mdu_op_e               op_i,
   input  logic [DATA_W-1:0]     a_mag_i,
   input  logic [DATA_W-1:0]     b_mag_i,
   input  logic                  sign_a_i,
   input  logic                  sign_b_i,
   input  logic [2*DATA_W-1:0]   work_i,
   output logic [2*DATA_W-1:0]   work_next_o,
   output logic [DATA_W-1:0]     fin_hi_o,
   output logic [DATA_W-1:0]     fin_lo_o
);

   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     rem_sh;
   logic [DATA_W-1:0]   rem_sub;
   logic                rem_ge;
   logic [2*DATA_W-1:0] prod_fix;
   logic                neg_res;
   logic                neg_a;

   always_comb begin
      mag_a_o = (sign_mode_i && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
      mag_b_o = (sign_mode_i && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;

      // Multiply: work = {partial sum, remaining multiplier bits}, shifted right.
      mul_sum = {1'b0, work_i[2*DATA_W-1:DATA_W]}
              + (work_i[0] ? {1'b0, a_mag_i} : {(DATA_W+1){1'b0}});
      // Divide: work = {remainder, dividend bits / quotient bits}, shifted left.
      rem_sh  = work_i[2*DATA_W-1:DATA_W-1];
      rem_ge  = (rem_sh >= {1'b0, b_mag_i});
      rem_sub = rem_sh[DATA_W-1:0] - b_mag_i;

      if (op_is_div(op_i)) begin
         work_next_o = rem_ge ? {rem_sub, work_i[DATA_W-2:0], 1'b1}
                              : {rem_sh[DATA_W-1:0], work_i[DATA_W-2:0], 1'b0};
      end else begin
         work_next_o = {mul_sum, work_i[DATA_W-1:1]};
      end

      neg_res  = op_is_signed(op_i) & (sign_a_i ^ sign_b_i);
      neg_a    = op_is_signed(op_i) & sign_a_i;
      prod_fix = neg_res ? -work_next_o : work_next_o;

      if (!op_is_div(op_i)) begin
         fin_hi_o = prod_fix[2*DATA_W-1:DATA_W];
         fin_lo_o = prod_fix[DATA_W-1:0];
      end else if (b_mag_i == '0) begin
         fin_hi_o = neg_a ? -a_mag_i : a_mag_i;
         fin_lo_o = '1;
      end else begin
         fin_hi_o = neg_a   ? -work_next_o[2*DATA_W-1:DATA_W] : work_next_o[2*DATA_W-1:DATA_W];
         fin_lo_o = neg_res ? -work_next_o[DATA_W-1:0]        : work_next_o[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: accepts an op in IDLE, iterates DATA_W
// cycles while stalling the pipe, then presents HI/LO for one cycle.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              op_div,
   input  logic              op_signed,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic              stall,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo
);

   mdu_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   mdu_op_e             op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [2*DATA_W-1:0] work_q, work_d;
   logic [DATA_W-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;

   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [2*DATA_W-1:0] work_next;
   logic [DATA_W-1:0]   fin_hi, fin_lo;

   mdu_iter_core #(.DATA_W(DATA_W)) u_core (
      .sign_mode_i (op_signed),
      .src_a_i     (src_a),
      .src_b_i     (src_b),
      .mag_a_o     (mag_a),
      .mag_b_o     (mag_b),
      .op_i        (op_q),
      .a_mag_i     (a_q),
      .b_mag_i     (b_q),
      .sign_a_i    (sign_a_q),
      .sign_b_i    (sign_b_q),
      .work_i      (work_q),
      .work_next_o (work_next),
      .fin_hi_o    (fin_hi),
      .fin_lo_o    (fin_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      work_d    = work_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      stall     = 1'b0;
      res_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               stall    = 1'b1;
               op_d     = mdu_op_e'({op_div, op_signed});
               a_d      = mag_a;
               b_d      = mag_b;
               sign_a_d = src_a[DATA_W-1];
               sign_b_d = src_b[DATA_W-1];
               work_d   = {{DATA_W{1'b0}}, (op_div ? mag_a : mag_b)};
               cnt_d    = '0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            stall  = 1'b1;
            work_d = work_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1) && !flush) begin
               res_hi_d = fin_hi;
               res_lo_d = fin_lo;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            res_valid = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) state_d = ST_IDLE;
      // Keep the pipe free while reset is asserted, whatever state is held.
      if (!resetn) stall = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MULTU;
         a_q      <= '0;
         b_q      <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         work_q   <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         work_q   <= work_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   assign res_hi = res_hi_q;
   assign res_lo = res_lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_mdu_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn;
   logic         start;
   logic         op_div;
   logic         op_signed;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         flush;
   logic         stall;
   logic         res_valid;
   logic [W-1:0] res_hi;
   logic [W-1:0] res_lo;

   int n_checks = 0;
   int n_errors = 0;

   mdu_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .op_div    (op_div),
      .op_signed (op_signed),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .stall     (stall),
      .res_valid (res_valid),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic from the architectural definition.
   task automatic model(input logic dv, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] hi, output logic [W-1:0] lo);
      logic [63:0] p;
      int          sa, sb;
      if (!dv) begin
         if (sg) p = 64'($signed({{32{a[W-1]}}, a}) * $signed({{32{b[W-1]}}, b}));
         else    p = {32'd0, a} * {32'd0, b};
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 0) begin
         hi = a;
         lo = '1;
      end else if (sg) begin
         sa = a;
         sb = b;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = 0;
            lo = 32'h8000_0000;
         end else begin
            hi = sa % sb;
            lo = sa / sb;
         end
      end else begin
         hi = a % b;
         lo = a / b;
      end
   endtask

   // Runs one op starting at the next cycle T, checking stall/res_valid every
   // cycle up to T+33 and the result there. start stays high through DONE.
   task automatic run_op(input logic dv, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic flush_in_done);
      logic [W-1:0] eh, el;
      model(dv, sg, a, b, eh, el);
      @(negedge clk);
      start = 1'b1; op_div = dv; op_signed = sg; src_a = a; src_b = b; flush = 1'b0;
      #1;
      for (int k = 0; k <= 33; k++) begin
         if (k > 0) begin
            @(negedge clk);
            src_a = $urandom;
            src_b = $urandom;
            if (k == 33) flush = flush_in_done;
            #1;
         end
         check($sformatf("stall@T+%0d", k), 64'(stall), 64'(k <= 32));
         check($sformatf("valid@T+%0d", k), 64'(res_valid), 64'(k == 33));
      end
      check("res_hi", 64'(res_hi), 64'(eh));
      check("res_lo", 64'(res_lo), 64'(el));
      $display("op div=%0d sgn=%0d a=%h b=%h -> hi=%h lo=%h (model %h %h)",
               dv, sg, a, b, res_hi, res_lo, eh, el);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("valid_after", 64'(res_valid), 64'd0);
      check("stall_after", 64'(stall), 64'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rd, rs;
      resetn = 1'b0; start = 1'b0; op_div = 1'b0; op_signed = 1'b0;
      src_a = '0; src_b = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", 64'(stall), 64'd0);
      resetn = 1'b1;
      #1;
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_hi", 64'(res_hi), 64'd0);
      check("rst_lo", 64'(res_lo), 64'd0);
      check("rst_idle_stall", 64'(stall), 64'd0);

      run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
      run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
      run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);

      // Flush at T+10 of a new op, then DIVU 9/3 started at T+12.
      @(negedge clk);
      start = 1'b1; op_div = 1'b1; op_signed = 1'b0; src_a = 32'd1000; src_b = 32'd3;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_cycle_stall", 64'(stall), 64'd1);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_next_stall", 64'(stall), 64'd0);
      check("flush_next_valid", 64'(res_valid), 64'd0);
      run_op(1'b1, 1'b0, 32'd9, 32'd3, 1'b0);

      // Reset for one cycle at T+20 of a MULT.
      @(negedge clk);
      start = 1'b1; op_div = 1'b0; op_signed = 1'b1; src_a = 32'h1234_5678; src_b = 32'hFFFF_0001;
      for (int k = 1; k <= 20; k++) @(negedge clk);
      start = 1'b0; resetn = 1'b0;
      #1;
      check("rst_mid_stall", 64'(stall), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("rst_mid_next_stall", 64'(stall), 64'd0);
      check("rst_mid_valid", 64'(res_valid), 64'd0);
      check("rst_mid_hi", 64'(res_hi), 64'd0);
      check("rst_mid_lo", 64'(res_lo), 64'd0);

      // Simultaneous start and flush in IDLE: nothing accepted.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op_div = 1'b1; op_signed = 1'b0; src_a = 32'd50; src_b = 32'd5;
      #1;
      check("startflush_stall", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         check("startflush_no_valid", 64'(res_valid | stall), 64'd0);
      end

      // Random ops, with occasional boundary operands.
      for (int i = 0; i < 14; i++) begin
         rd = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(rd, rs, ra, rb, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide unit and its sequencer for the EX stage.
- Executes the MULT, MULTU, DIV and DIVU control classes produced by instruction decode, with 32 shift-add or shift-subtract iterations.
- Stalls the pipeline while busy and presents a one-cycle HI/LO result, which the HI/LO write path (alu_res source) captures.
- Supports cancellation by an exception flush.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  EX holds a mul/div instruction (level, held high until EX advances).
- op_div  in  1  1 = divide, 0 = multiply.
- op_signed  in  1  1 = signed (DIV/MULT), 0 = unsigned (DIVU/MULTU).
- src_a  in  DATA_W  rs_data (multiplicand / dividend).
- src_b  in  DATA_W  rt_data (multiplier / divisor).
- flush  in  1  exception/ERET flush of EX.
- stall  out  1  freeze IF/ID/EX.
- res_valid  out  1  HI/LO result valid this cycle.
- res_hi  out  DATA_W  product[63:32] or remainder.
- res_lo  out  DATA_W  product[31:0] or quotient.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (resetn = 0 at a clk edge): state IDLE, counter 0, res_valid 0, res_hi 0, res_lo 0, internal registers 0. stall is 0 during and after reset. Reset mid-operation discards the operation.
- IDLE:
  - start = 1 and flush = 0: latch op_div and op_signed; latch |src_a| and |src_b| (magnitudes if op_signed, raw values otherwise); latch the result-sign bits; counter = 0; go to BUSY.
  - Otherwise remain in IDLE.
- BUSY: one iteration per cycle; counter increments; after the iteration with counter = DATA_W-1, go to DONE.
  - Multiply: 2*DATA_W-bit shift-add on the magnitudes.
  - Divide: restoring shift-subtract on the magnitudes.
- DONE: res_valid = 1 for exactly one cycle. Next state is unconditionally IDLE.
  - start is ignored in DONE, because it is the same instruction still held in EX.
- Latency: start sampled in IDLE at cycle T; res_valid = 1 in cycle T+33.
- stall (combinational) = (IDLE & start & ~flush) | BUSY. stall is 0 in DONE, so EX advances in the result cycle.
- Sign fix, applied when entering DONE, signed ops only:
  - Product is negated if src_a and src_b signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / -1 yields lo = 0x80000000, hi = 0.
- Divide by zero (src_b = 0, any sign mode): res_hi = src_a as latched (unmodified), res_lo = all ones. Latency is unchanged and no exception is raised.
- res_hi and res_lo hold their last value outside DONE. Consumers qualify them with res_valid only.
- flush = 1 in any state: next state IDLE, res_valid 0 next cycle, no result produced.
  - flush overrides start in the same cycle.
  - flush in DONE suppresses nothing already emitted; res_valid in that cycle stays 1, and the consumer gates the write with its own flush.
- start while BUSY is ignored. Operands are sampled only on IDLE acceptance, so src_a and src_b may change afterwards.

Decomposition:
- Shared package (mdu_pkg) holds:
  - state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - DATA_W default;
  - the op encoding {op_div, op_signed} shared with the decode control outputs.
- One sub-module, mdu_iter_core: the combinational single-iteration step for shift-add and shift-subtract, plus the magnitude/negate helpers.
- mdu_ctrl owns the FSM, counter, registers and stall.

Test Plan:
- DIVU 100/7 started at T: stall = 1 in cycles T..T+32; res_valid only in T+33 with hi = 2, lo = 14.
- DIV 0xFFFFFFF9 (-7) / 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MULT 0xFFFFFFFF * 2: hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU with the same operands: hi = 0x00000001, lo = 0xFFFFFFFE.
- DIVU 5/0 and DIV 0xFFFFFFFB/0: hi equals src_a, lo = 0xFFFFFFFF, latency 33.
- start held through DONE: exactly one res_valid pulse. Then flush asserted at T+10 of a new op: state IDLE and stall = 0 at T+11, no res_valid. New DIVU 9/3 at T+12 gives hi = 0, lo = 3 at T+45.
- resetn = 0 for one cycle at T+20 of a MULT: all outputs 0 and stall = 0 the next cycle. Simultaneous start and flush in IDLE: start not accepted.
